axis_tx_framer: RTL
===================

# axis_tx_framer

Transmit-direction counterpart of the MAC-side receive adapter: accepts 512-bit words from the CASPER yellow block and presents them to the 400G MAC as an AXI4-Stream TX frame. Frames are stored and forwarded, so `axis_tx_tvalid` never drops mid-frame, which the MAC requires. A frame that cannot fit is dropped whole and flagged on `yellow_block_tx_overrun`. Single clock domain; any CDC from the yellow-block user clock happens upstream.

## Interface
- `DATA_W`, 512, data width in bits; keep width is `DATA_W/8`.
- `DEPTH_LOG2`, 6, FIFO depth is 2^DEPTH_LOG2 words (64); the largest frame accepted is that many words.
- `AFULL_MARGIN`, 8, `yellow_block_tx_afull` asserts when free words are at or below this value.

Ports:
- `axis_tx_clkin` in 1: the only clock, rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `yellow_block_tx_data` in DATA_W: payload word.
- `yellow_block_tx_valid` in 1: word present this cycle. There is no backpressure on this side.
- `yellow_block_tx_keep` in DATA_W/8: byte enables. Only honoured on the eof word; non-eof words are stored as all ones.
- `yellow_block_tx_eof` in 1: last word of the frame; qualified by valid.
- `yellow_block_tx_overrun` out 1: one-cycle pulse when a frame is dropped.
- `yellow_block_tx_afull` out 1: almost-full hint.
- `axis_tx_tdata` out DATA_W, `axis_tx_tkeep` out DATA_W/8, `axis_tx_tlast` out 1, `axis_tx_tvalid` out 1: AXIS master to the MAC.
- `axis_tx_tready` in 1: MAC accept.
- `axis_tx_tuser` out 1: tied to 0.

## Operation
- Storage: 2^DEPTH_LOG2 entries, each holding {data, keep, eof}.
- Pointers are DEPTH_LOG2+1 bits wide and wrap naturally.
  - `wr_ptr`: speculative write pointer.
  - `commit_ptr`: end of the last complete frame.
  - `rd_ptr`: read pointer.
  - Used = `wr_ptr - rd_ptr`; full when used = 2^DEPTH_LOG2.
- `frames`: count of committed, unsent frames, DEPTH_LOG2+1 bits.

Write FSM states: WR_ACCEPT and WR_DROP.
- WR_ACCEPT, valid and not full:
  - store the word and increment `wr_ptr`;
  - if eof, set `commit_ptr` to the new `wr_ptr` and increment `frames`.
- WR_ACCEPT, valid and full:
  - discard the word and pulse overrun;
  - rewind `wr_ptr` to `commit_ptr`;
  - if eof, stay in WR_ACCEPT; otherwise go to WR_DROP.
- WR_DROP: discard every valid word. On a valid eof, return to WR_ACCEPT; that word is also discarded.

Read FSM states: RD_IDLE and RD_SEND.
- RD_IDLE: when `frames` > 0, go to RD_SEND.
- RD_SEND:
  - tvalid = 1; tdata, tkeep and tlast come from entry `rd_ptr` (combinational LUTRAM read).
  - On a tready handshake: increment `rd_ptr`.
  - If tlast was also set, decrement `frames`. Stay in RD_SEND if the post-update count is > 0, else go to RD_IDLE.
- The read side never reads past `commit_ptr`.

Simultaneous events:
- Commit and last-word handshake in the same cycle: `frames` is unchanged.
- A rewind never moves `wr_ptr` below `rd_ptr`, because `commit_ptr` is always at or above `rd_ptr`.

## Timing
- Reset values:
  - all pointers and `frames` = 0;
  - states = WR_ACCEPT and RD_IDLE;
  - tvalid, tlast, overrun, tuser = 0; afull = 0;
  - tdata and tkeep = 0.
- Latency: an eof written at edge N makes `frames` = 1 after N. RD_SEND is entered at N+1, and the first-word tvalid is high from N+1 to N+2.
- Once asserted, tvalid stays high without bubbles until the tlast handshake completes. tdata, tkeep and tlast are stable while tvalid is high and tready is low.
- Back-to-back frames: the next frame's first word follows tlast with zero idle cycles if it is already committed.
- `afull` is registered, one cycle behind the pointers.
- Overrun is registered and asserted in the cycle after the rejected word.
- Reset asserted mid-frame: both sides abort immediately and the partial frame is lost. tvalid deasserts asynchronously.

## Structure
- Shared package `axis_tx_pkg`:
  - `DATA_W` and `KEEP_W` constants;
  - `wr_state_t` {WR_ACCEPT, WR_DROP} and `rd_state_t` {RD_IDLE, RD_SEND};
  - the FIFO entry struct {data, keep, eof}.
- Sub-module `axis_tx_frame_ram`: simple dual-port memory with synchronous write and asynchronous read, parameterised by width and DEPTH_LOG2.
- The top level holds the pointers, both FSMs and the flags.

## Test plan
- Single 3-word frame with eof keep = 0x0000_0000_0000_FFFF and tready held at 1 → three consecutive tvalid beats starting 2 cycles after eof. tlast is on beat 3 with that keep; beats 1–2 have keep all ones.
- Two back-to-back 2-word frames, tready = 1 → four contiguous beats with tlast on beats 2 and 4, no idle cycle between them.
- tready toggled 1/0 every cycle during a 5-word frame → tvalid held high throughout, and data is stable while stalled. All 5 words arrive in order.
- 70-word frame with DEPTH_LOG2 = 6 → overrun pulses once on the word that finds the FIFO full, and no AXIS beat is emitted. A following 4-word frame is then sent intact.
- Fill with 60 committed words while tready = 0 → afull asserts once free words ≤ 8. A new 8-word frame drops with overrun = 1, and the committed frames still drain correctly.
- Reset_n pulsed low while in RD_SEND mid-frame → tvalid = 0 immediately and `frames` = 0. After release, a new 1-word frame transmits normally.

Source files
------------

// File: rtl/axis_tx_pkg.sv
// Shared types for the store-and-forward AXIS TX framer.
package axis_tx_pkg;

    localparam int DATA_W = 512;
    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic {WR_ACCEPT, WR_DROP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_SEND} rd_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              eof;
    } tx_entry_t;

endpackage

// File: rtl/axis_tx_frame_ram.sv
// Simple dual-port frame store: synchronous write, asynchronous (LUTRAM) read.
module axis_tx_frame_ram #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_tx_framer.sv
// Store-and-forward TX framer: buffers whole frames from the yellow block and
// replays them to the MAC without tvalid bubbles; oversize/overflowing frames are dropped whole.
module axis_tx_framer
    import axis_tx_pkg::*;
#(
    parameter int DATA_W       = axis_tx_pkg::DATA_W,
    parameter int DEPTH_LOG2   = 6,
    parameter int AFULL_MARGIN = 8
) (
    input  logic                axis_tx_clkin,
    input  logic                Reset_n,
    input  logic [DATA_W-1:0]   yellow_block_tx_data,
    input  logic                yellow_block_tx_valid,
    input  logic [DATA_W/8-1:0] yellow_block_tx_keep,
    input  logic                yellow_block_tx_eof,
    output logic                yellow_block_tx_overrun,
    output logic                yellow_block_tx_afull,
    output logic [DATA_W-1:0]   axis_tx_tdata,
    output logic [DATA_W/8-1:0] axis_tx_tkeep,
    output logic                axis_tx_tlast,
    output logic                axis_tx_tvalid,
    input  logic                axis_tx_tready,
    output logic                axis_tx_tuser
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2 + 1;

    logic [PTR_W-1:0] wr_ptr, commit_ptr, rd_ptr;
    logic [PTR_W-1:0] frames, frames_next, used;
    wr_state_t        wr_state;
    rd_state_t        rd_state;
    tx_entry_t        wr_entry, rd_entry;
    logic             full, wr_en, commit, rd_hs, last_hs;

    assign used        = wr_ptr - rd_ptr;
    assign full        = (used == PTR_W'(DEPTH));
    assign wr_en       = (wr_state == WR_ACCEPT) && yellow_block_tx_valid && !full;
    assign commit      = wr_en && yellow_block_tx_eof;
    assign rd_hs       = (rd_state == RD_SEND) && axis_tx_tready;
    assign last_hs     = rd_hs && rd_entry.eof;
    // a commit and a last-beat handshake in the same cycle cancel out
    assign frames_next = frames + PTR_W'(commit) - PTR_W'(last_hs);

    always_comb begin
        wr_entry.data = yellow_block_tx_data;
        wr_entry.keep = yellow_block_tx_eof ? yellow_block_tx_keep : '1;
        wr_entry.eof  = yellow_block_tx_eof;
    end

    axis_tx_frame_ram #(
        .WIDTH      ($bits(tx_entry_t)),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (axis_tx_clkin),
        .we    (wr_en),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata (rd_entry)
    );

    always_ff @(posedge axis_tx_clkin or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_state                <= WR_ACCEPT;
            wr_ptr                  <= '0;
            commit_ptr              <= '0;
            yellow_block_tx_overrun <= 1'b0;
            yellow_block_tx_afull   <= 1'b0;
        end else begin
            yellow_block_tx_overrun <= 1'b0;
            yellow_block_tx_afull   <= (PTR_W'(DEPTH) - used) <= PTR_W'(AFULL_MARGIN);
            case (wr_state)
                WR_ACCEPT: if (yellow_block_tx_valid) begin
                    if (!full) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (yellow_block_tx_eof) commit_ptr <= wr_ptr + 1'b1;
                    end else begin
                        // drop the partial frame; commit_ptr never trails rd_ptr
                        yellow_block_tx_overrun <= 1'b1;
                        wr_ptr                  <= commit_ptr;
                        if (!yellow_block_tx_eof) wr_state <= WR_DROP;
                    end
                end
                WR_DROP: if (yellow_block_tx_valid && yellow_block_tx_eof) wr_state <= WR_ACCEPT;
                default: wr_state <= WR_ACCEPT;
            endcase
        end
    end

    always_ff @(posedge axis_tx_clkin or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_state <= RD_IDLE;
            rd_ptr   <= '0;
            frames   <= '0;
        end else begin
            frames <= frames_next;
            case (rd_state)
                RD_IDLE: if (frames != '0) rd_state <= RD_SEND;
                RD_SEND: if (rd_hs) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    if (rd_entry.eof && frames_next == '0) rd_state <= RD_IDLE;
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    assign axis_tx_tvalid = (rd_state == RD_SEND);
    assign axis_tx_tdata  = axis_tx_tvalid ? rd_entry.data : '0;
    assign axis_tx_tkeep  = axis_tx_tvalid ? rd_entry.keep : '0;
    assign axis_tx_tlast  = axis_tx_tvalid && rd_entry.eof;
    assign axis_tx_tuser  = 1'b0;

endmodule
